// File: rtl/rvc_asap_pkg.sv
// rtl/rvc_asap_pkg.sv - shared rvc_asap constants: CR register offsets and byte-merge helper
package rvc_asap_pkg;

  localparam logic [7:0] CR_SEG7_BASE = 8'h00;
  localparam logic [7:0] CR_LED       = 8'h20;
  localparam logic [7:0] CR_BTN_LEVEL = 8'h24;
  localparam logic [7:0] CR_SWITCH    = 8'h28;
  localparam logic [7:0] CR_CURSOR_H  = 8'h2C;
  localparam logic [7:0] CR_CURSOR_V  = 8'h30;
  localparam logic [7:0] CR_BTN_EDGE  = 8'h34;
  localparam logic [7:0] CR_BTN_MASK  = 8'h38;

  localparam int         MAX_SEG7 = 8;
  localparam logic [7:0] SEG7_RST = 8'hFF;

  // Replace only the bytes selected by be, keep the rest of old_val.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/rvc_asap_cr_debounce.sv
// rtl/rvc_asap_cr_debounce.sv - one-button 2-flop synchroniser plus stable-level debouncer
// Debounce counter present only when RVC_ASAP_CR_DEBOUNCE_EN is defined.
module rvc_asap_cr_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_level
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef RVC_ASAP_CR_DEBOUNCE_EN
  localparam int             CW      = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Accept a change only after it has been stable for DEBOUNCE_CYC cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign o_level = r_level;
`else
  localparam int unused_debounce_cyc = DEBOUNCE_CYC;

  assign o_level = r_sync2;
`endif

endmodule

// File: rtl/rvc_asap_cr_ctrl.sv
// rtl/rvc_asap_cr_ctrl.sv - rvc_asap CR window: display/LED/cursor registers, buttons, switches, IRQ
// Button debouncing is enabled by defining RVC_ASAP_CR_DEBOUNCE_EN.
module rvc_asap_cr_ctrl
  import rvc_asap_pkg::*;
#(
  parameter logic [31:0] CR_BASE      = 32'h2000,
  parameter int          NUM_SEG7     = 6,
  parameter int          LED_W        = 10,
  parameter int          SW_W         = 10,
  parameter int          NUM_BTN      = 2,
  parameter int          DEBOUNCE_CYC = 50000
) (
  input  logic                  Clock,
  input  logic                  Rst_N,
  input  logic                  RdEn,
  input  logic                  WrEn,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WrData,
  input  logic [3:0]            ByteEn,
  output logic [31:0]           RdData,
  input  logic [NUM_BTN-1:0]    Button,
  input  logic [SW_W-1:0]       Switch,
  output logic [8*NUM_SEG7-1:0] Seg7,
  output logic [LED_W-1:0]      Led,
  output logic [31:0]           CursorH,
  output logic [31:0]           CursorV,
  output logic                  BtnIrq
);

  logic [7:0]         r_seg7 [NUM_SEG7];
  logic [LED_W-1:0]   r_led;
  logic [31:0]        r_cur_h;
  logic [31:0]        r_cur_v;
  logic [NUM_BTN-1:0] r_btn_mask;
  logic [NUM_BTN-1:0] r_btn_edge;
  logic [NUM_BTN-1:0] r_btn_prev;
  logic [SW_W-1:0]    r_sw_s1;
  logic [SW_W-1:0]    r_sw_s2;
  logic               r_irq;
  logic [31:0]        r_rd_data;

  logic               w_hit;
  logic [7:0]         w_off;
  logic               w_wr;
  logic [1:0]         w_unused_addr;
  logic [NUM_BTN-1:0] w_btn_level;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_clr;
  logic [31:0]        w_rd_val;

  assign w_hit         = (Addr[31:8] == CR_BASE[31:8]);
  assign w_off         = {Addr[7:2], 2'b00};
  assign w_wr          = WrEn & w_hit;
  assign w_unused_addr = Addr[1:0];

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    rvc_asap_cr_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .i_clk     (Clock),
      .i_rst_n   (Rst_N),
      .i_btn_raw (Button[b]),
      .o_level   (w_btn_level[b])
    );
  end

  // A new press on the same edge as a W1C clear must survive, so set wins.
  assign w_rise = w_btn_level & ~r_btn_prev;
  assign w_clr  = (w_wr && w_off == CR_BTN_EDGE) ?
                  (WrData[NUM_BTN-1:0] & {NUM_BTN{ByteEn[0]}}) : '0;

  always_ff @(posedge Clock) begin
    if (!Rst_N) begin
      for (int i = 0; i < NUM_SEG7; i++) r_seg7[i] <= SEG7_RST;
      r_led      <= '0;
      r_cur_h    <= '0;
      r_cur_v    <= '0;
      r_btn_mask <= '0;
      r_btn_edge <= '0;
      r_btn_prev <= '0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_sw_s1    <= Switch;
      r_sw_s2    <= r_sw_s1;
      r_btn_prev <= w_btn_level;
      r_btn_edge <= (r_btn_edge & ~w_clr) | w_rise;
      r_irq      <= |(r_btn_edge & r_btn_mask);
      if (w_wr) begin
        for (int i = 0; i < NUM_SEG7; i++)
          if (w_off == CR_SEG7_BASE + 8'(4 * i) && ByteEn[0]) r_seg7[i] <= WrData[7:0];
        if (w_off == CR_LED)
          r_led <= LED_W'(be_merge(32'(r_led), WrData, ByteEn));
        if (w_off == CR_CURSOR_H)
          r_cur_h <= be_merge(r_cur_h, WrData, ByteEn);
        if (w_off == CR_CURSOR_V)
          r_cur_v <= be_merge(r_cur_v, WrData, ByteEn);
        if (w_off == CR_BTN_MASK)
          r_btn_mask <= NUM_BTN'(be_merge(32'(r_btn_mask), WrData, ByteEn));
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (w_hit) begin
      case (w_off)
        CR_LED:       w_rd_val = 32'(r_led);
        CR_BTN_LEVEL: w_rd_val = 32'(w_btn_level);
        CR_SWITCH:    w_rd_val = 32'(r_sw_s2);
        CR_CURSOR_H:  w_rd_val = r_cur_h;
        CR_CURSOR_V:  w_rd_val = r_cur_v;
        CR_BTN_EDGE:  w_rd_val = 32'(r_btn_edge);
        CR_BTN_MASK:  w_rd_val = 32'(r_btn_mask);
        default: begin
          for (int i = 0; i < NUM_SEG7; i++)
            if (w_off == CR_SEG7_BASE + 8'(4 * i)) w_rd_val = {24'd0, r_seg7[i]};
        end
      endcase
    end
  end

  // Read data is captured from pre-write state and held until the next read.
  always_ff @(posedge Clock) begin
    if (!Rst_N)    r_rd_data <= '0;
    else if (RdEn) r_rd_data <= w_rd_val;
  end

  for (genvar i = 0; i < NUM_SEG7; i++) begin : g_seg7
    assign Seg7[8*i +: 8] = r_seg7[i];
  end

  assign RdData  = r_rd_data;
  assign Led     = r_led;
  assign CursorH = r_cur_h;
  assign CursorV = r_cur_v;
  assign BtnIrq  = r_irq;

endmodule
